// File: rtl/sysbus_rr_scheduler_pkg.sv
// Shared types and constants for the Sysbus round-robin scheduler.
package sysbus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int REQ_ICACHE      = 0;
    localparam int REQ_DREAD       = 1;
    localparam int REQ_DWB         = 2;

    localparam int BEATS_DEFAULT   = 8;
    localparam int TIMEOUT_DEFAULT = 1023;

    // Width of an index over n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sysbus_rr_scheduler_if.sv
// Cache-side request/response lanes plus the single Sysbus port.
// master: the scheduler. slave: the caches and the memory side.
interface sysbus_rr_scheduler_if #(
    parameter int WIDTH     = 64,
    parameter int TAG_WIDTH = 13,
    parameter int NREQ      = 3
);
    logic [NREQ-1:0]           cl_reqcyc;
    logic [NREQ*WIDTH-1:0]     cl_req;
    logic [NREQ*TAG_WIDTH-1:0] cl_reqtag;
    logic [NREQ-1:0]           cl_wr;
    logic [NREQ*WIDTH-1:0]     cl_wdata;
    logic [NREQ-1:0]           cl_reqack;
    logic [NREQ-1:0]           cl_wnext;
    logic [NREQ-1:0]           cl_respcyc;
    logic [WIDTH-1:0]          cl_resp;
    logic [TAG_WIDTH-1:0]      cl_resptag;
    logic [NREQ-1:0]           cl_err;

    logic                      bus_reqcyc;
    logic [WIDTH-1:0]          bus_req;
    logic [TAG_WIDTH-1:0]      bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic [WIDTH-1:0]          bus_resp;
    logic [TAG_WIDTH-1:0]      bus_resptag;
    logic                      bus_respack;

    modport master (
        input  cl_reqcyc, cl_req, cl_reqtag, cl_wr, cl_wdata,
        output cl_reqack, cl_wnext, cl_respcyc, cl_resp, cl_resptag, cl_err,
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        output cl_reqcyc, cl_req, cl_reqtag, cl_wr, cl_wdata,
        input  cl_reqack, cl_wnext, cl_respcyc, cl_resp, cl_resptag, cl_err,
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

endinterface

// File: rtl/sysbus_rr_scheduler_rr_pick.sv
// Round-robin priority search: first asserted request at or above base,
// wrapping back to index 0.
module rr_pick
    import sysbus_sched_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   base,
    output logic            found,
    output logic [PW-1:0]   idx
);

    // Walk the requesters starting at base; the first hit wins.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(base) + k) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/sysbus_rr_scheduler.sv
// Shares one Sysbus memory port among the cache requesters. Grants in
// round-robin order, sends address and write beats, forwards response
// beats to the owner only and aborts a burst if memory stops answering.
module sysbus_rr_scheduler
    import sysbus_sched_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int TAG_WIDTH = 13,
    parameter int NREQ      = 3,
    parameter int BEATS     = BEATS_DEFAULT,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    sysbus_rr_scheduler_if.master bif
);

    localparam int PW   = idx_width(NREQ);
    localparam int BC_W = $clog2(BEATS + 1);
    localparam int WC_W = idx_width(BEATS);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t               state, state_nxt;
    logic [PW-1:0]        rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]        owner, owner_nxt;
    logic                 owner_wr, owner_wr_nxt;
    logic [BC_W-1:0]      beat_cnt, beat_cnt_nxt;
    logic [WC_W-1:0]      wd_cnt, wd_cnt_nxt;
    logic [WD_W-1:0]      wdog, wdog_nxt;

    logic [NREQ-1:0]      reqack_q, reqack_nxt;
    logic [NREQ-1:0]      wnext_q, wnext_nxt;
    logic [NREQ-1:0]      respcyc_q, respcyc_nxt;
    logic [NREQ-1:0]      err_q, err_nxt;
    logic [WIDTH-1:0]     resp_q, resp_nxt;
    logic [TAG_WIDTH-1:0] resptag_q, resptag_nxt;
    logic                 bus_reqcyc_q, bus_reqcyc_nxt;
    logic [WIDTH-1:0]     bus_req_q, bus_req_nxt;
    logic [TAG_WIDTH-1:0] bus_reqtag_q, bus_reqtag_nxt;
    logic                 bus_respack_q, bus_respack_nxt;

    logic                 pick_found;
    logic [PW-1:0]        pick_idx;
    logic [NREQ-1:0]      owner_oh;
    logic [WIDTH-1:0]     owner_wdata;
    logic                 progress;
    logic                 timeout_hit;
    logic                 last_beat;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (bif.cl_reqcyc),
        .base  (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_oh    = NREQ'(1) << owner;
    assign owner_wdata = bif.cl_wdata[int'(owner)*WIDTH +: WIDTH];

    // Any accepted request word or response beat counts as progress and
    // holds off the watchdog.
    assign progress    = ((state == ADDR || state == WDATA) && bif.bus_reqack) ||
                         ((state == RESP) && bif.bus_respcyc);
    assign timeout_hit = (state != IDLE) && !progress && (wdog == WD_W'(TIMEOUT));

    // A write burst completes with a single response beat.
    assign last_beat   = owner_wr ? (beat_cnt == BC_W'(0)) : (beat_cnt == BC_W'(BEATS - 1));

    // Next-state and next-output logic; pulses default low, bus fields hold.
    always_comb begin
        state_nxt       = state;
        rr_ptr_nxt      = rr_ptr;
        owner_nxt       = owner;
        owner_wr_nxt    = owner_wr;
        beat_cnt_nxt    = beat_cnt;
        wd_cnt_nxt      = wd_cnt;
        wdog_nxt        = wdog;
        reqack_nxt      = '0;
        wnext_nxt       = '0;
        respcyc_nxt     = '0;
        err_nxt         = '0;
        resp_nxt        = resp_q;
        resptag_nxt     = resptag_q;
        bus_reqcyc_nxt  = bus_reqcyc_q;
        bus_req_nxt     = bus_req_q;
        bus_reqtag_nxt  = bus_reqtag_q;
        bus_respack_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    reqack_nxt     = NREQ'(1) << pick_idx;
                    bus_reqcyc_nxt = 1'b1;
                    bus_req_nxt    = bif.cl_req[int'(pick_idx)*WIDTH +: WIDTH];
                    bus_reqtag_nxt = bif.cl_reqtag[int'(pick_idx)*TAG_WIDTH +: TAG_WIDTH];
                    owner_nxt      = pick_idx;
                    owner_wr_nxt   = bif.cl_wr[pick_idx];
                    rr_ptr_nxt     = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
                    wdog_nxt       = '0;
                    state_nxt      = ADDR;
                end
            end
            ADDR: begin
                if (bif.bus_reqack) begin
                    wdog_nxt = '0;
                    if (!owner_wr) begin
                        bus_reqcyc_nxt = 1'b0;
                        state_nxt      = RESP;
                    end else begin
                        bus_req_nxt = owner_wdata;
                        wnext_nxt   = owner_oh;
                        wd_cnt_nxt  = '0;
                        state_nxt   = WDATA;
                    end
                end else begin
                    wdog_nxt = wdog + WD_W'(1);
                end
            end
            WDATA: begin
                if (bif.bus_reqack) begin
                    wdog_nxt = '0;
                    if (int'(wd_cnt) < BEATS - 1) begin
                        wd_cnt_nxt  = wd_cnt + WC_W'(1);
                        bus_req_nxt = owner_wdata;
                        wnext_nxt   = owner_oh;
                    end else begin
                        wd_cnt_nxt     = '0;
                        bus_reqcyc_nxt = 1'b0;
                        state_nxt      = RESP;
                    end
                end else begin
                    wdog_nxt = wdog + WD_W'(1);
                end
            end
            RESP: begin
                if (bif.bus_respcyc) begin
                    respcyc_nxt     = owner_oh;
                    resp_nxt        = bif.bus_resp;
                    resptag_nxt     = bif.bus_resptag;
                    bus_respack_nxt = 1'b1;
                    wdog_nxt        = '0;
                    if (last_beat) begin
                        beat_cnt_nxt = '0;
                        state_nxt    = IDLE;
                    end else begin
                        beat_cnt_nxt = beat_cnt + BC_W'(1);
                    end
                end else begin
                    wdog_nxt = wdog + WD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Memory went silent: flag the owner and drop the bus.
        if (timeout_hit) begin
            err_nxt         = owner_oh;
            respcyc_nxt     = '0;
            bus_reqcyc_nxt  = 1'b0;
            bus_req_nxt     = '0;
            bus_reqtag_nxt  = '0;
            bus_respack_nxt = 1'b0;
            beat_cnt_nxt    = '0;
            wd_cnt_nxt      = '0;
            wdog_nxt        = '0;
            state_nxt       = IDLE;
        end
    end

    // FSM state, arbitration pointer, ownership and burst counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            owner_wr <= 1'b0;
            beat_cnt <= '0;
            wd_cnt   <= '0;
            wdog     <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            owner    <= owner_nxt;
            owner_wr <= owner_wr_nxt;
            beat_cnt <= beat_cnt_nxt;
            wd_cnt   <= wd_cnt_nxt;
            wdog     <= wdog_nxt;
        end
    end

    // Registered outputs toward the caches and the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            reqack_q      <= '0;
            wnext_q       <= '0;
            respcyc_q     <= '0;
            err_q         <= '0;
            resp_q        <= '0;
            resptag_q     <= '0;
            bus_reqcyc_q  <= 1'b0;
            bus_req_q     <= '0;
            bus_reqtag_q  <= '0;
            bus_respack_q <= 1'b0;
        end else begin
            reqack_q      <= reqack_nxt;
            wnext_q       <= wnext_nxt;
            respcyc_q     <= respcyc_nxt;
            err_q         <= err_nxt;
            resp_q        <= resp_nxt;
            resptag_q     <= resptag_nxt;
            bus_reqcyc_q  <= bus_reqcyc_nxt;
            bus_req_q     <= bus_req_nxt;
            bus_reqtag_q  <= bus_reqtag_nxt;
            bus_respack_q <= bus_respack_nxt;
        end
    end

    assign bif.cl_reqack   = reqack_q;
    assign bif.cl_wnext    = wnext_q;
    assign bif.cl_respcyc  = respcyc_q;
    assign bif.cl_err      = err_q;
    assign bif.cl_resp     = resp_q;
    assign bif.cl_resptag  = resptag_q;
    assign bif.bus_reqcyc  = bus_reqcyc_q;
    assign bif.bus_req     = bus_req_q;
    assign bif.bus_reqtag  = bus_reqtag_q;
    assign bif.bus_respack = bus_respack_q;

endmodule
